// File: rtl/imem_fetch_responder_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory fetch responder.
//
// Contents:
//   state_t    - responder FSM states (IDLE, READ, RESP)
//   FETCH_W    - width of one fetch line (64)
//   HALF_W     - width of one SPRAM word (16)
//   HALVES     - SPRAM words per fetch line (4)
//   CNT_W      - width of the issue/capture counter (counts 0..4)
//   MEM_AW_DEF - default SPRAM halfword address width (16K x 16)
//   hw_addr()  - SPRAM halfword address from line address bits and halfword index
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FETCH_W    = 64;
    localparam int HALF_W     = 16;
    localparam int HALVES     = 4;
    localparam int CNT_W      = 3;
    localparam int MEM_AW_DEF = 14;

    // line_hw is the byte line address bits [MEM_AW:3]; the line holds four
    // consecutive halfwords, so the halfword index fills the two low bits.
    function automatic logic [MEM_AW_DEF-1:0] hw_addr(
        input logic [MEM_AW_DEF-3:0] line_hw,
        input logic [1:0]            idx
    );
        return {line_hw, idx};
    endfunction

endpackage

// File: rtl/imem_fetch_responder_if.sv
// imem_fetch_responder_if: fetch request/response bundle between the
// instruction fetcher (master) and the memory-side responder (slave).
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. valid never waits for ready; once raised, valid and its
// payload hold until the transfer edge. ready may depend combinationally on
// other inputs (the responder forces req_ready low during flush).
//
// Signals:
//   req_valid/req_ready/req_addr           - fetch request (byte address)
//   resp_valid/resp_ready/resp_data/addr   - fetch line response
//   resp_fault                             - only with IMEM_FETCH_FAULT_EN defined
interface imem_fetch_responder_if #(
    parameter int ADDR_W = 32
);
    import imem_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic               resp_valid;
    logic               resp_ready;
    logic [FETCH_W-1:0] resp_data;
    logic [ADDR_W-1:0]  resp_addr;
`ifdef IMEM_FETCH_FAULT_EN
    logic               resp_fault;
`endif

    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
`ifdef IMEM_FETCH_FAULT_EN
        output resp_fault,
`endif
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_addr
    );

    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
`ifdef IMEM_FETCH_FAULT_EN
        input  resp_fault,
`endif
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_addr
    );

endinterface

// File: rtl/imem_fetch_responder_line_assembler.sv
// line_assembler: four 16-bit slots that collect SPRAM read data into one
// little-endian 64-bit fetch line (slot k drives bits [16k+15:16k]).
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears all slots)
//   clr       - synchronous clear of all slots (wins over capture)
//   cap_en    - write cap_data into slot cap_idx on this edge
//   cap_idx   - slot write index
//   cap_data  - SPRAM read data
//   line      - assembled fetch line
module line_assembler
    import imem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               cap_en,
    input  logic [1:0]         cap_idx,
    input  logic [HALF_W-1:0]  cap_data,
    output logic [FETCH_W-1:0] line
);

    logic [HALVES-1:0][HALF_W-1:0] slot_q;

    // Each capture replaces the whole slot, so a previous line never leaks in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else if (clr) begin
            slot_q <= '0;
        end else if (cap_en) begin
            slot_q[cap_idx] <= cap_data;
        end
    end

    assign line = slot_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: memory-side responder for the 64-bit instruction
// fetch interface. Accepts one request at a time, reads four consecutive
// halfwords from SPRAM (one-cycle registered read latency), and returns them
// as one little-endian fetch line.
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   flush       - abort current work (taken branch); overrides everything
//   fetch       - request/response bundle (slave modport)
//   mem_ren     - SPRAM read enable
//   mem_addr    - SPRAM halfword address
//   mem_rdata   - SPRAM read data, valid the cycle after mem_ren
//   dbg_state   - current FSM state
//
// Build option IMEM_FETCH_FAULT_EN: requests whose address bits above
// MEM_AW are nonzero skip the SPRAM read and answer at once with
// resp_fault=1 and resp_data=0. Without it those bits alias.
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    imem_fetch_responder_if.slave   fetch,
    output logic                    mem_ren,
    output logic [MEM_AW-1:0]       mem_addr,
    input  logic [HALF_W-1:0]       mem_rdata,
    output state_t                  dbg_state
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:3]  line_q, line_d;
    logic               fault_q, fault_d;
    logic               accept;
    logic               asm_clr;
    logic               asm_cap;
    logic [1:0]         asm_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            fault_q <= fault_d;
        end
    end

    // READ runs cnt 0..4: cnt 0..3 issue reads, cnt 1..4 capture the data
    // returned for the previous issue into slot cnt-1. cnt 4 is capture-only.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        line_d           = line_q;
        fault_d          = fault_q;
        asm_clr          = 1'b0;
        asm_cap          = 1'b0;
        asm_idx          = cnt_q[1:0] - 2'd1;
        mem_ren          = 1'b0;
        mem_addr         = '0;
        fetch.req_ready  = 1'b0;
        fetch.resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                fetch.req_ready = !flush;
            end
            READ: begin
                if (!cnt_q[2]) begin
                    mem_ren  = !flush;
                    mem_addr = hw_addr(line_q[MEM_AW:3], cnt_q[1:0]);
                end
                asm_cap = (cnt_q != '0) && !flush;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                fetch.resp_valid = 1'b1;
                // A consumed line frees the responder on the same edge, so a
                // waiting request can start right away (6-cycle line rate).
                fetch.req_ready  = fetch.resp_ready && !flush;
                if (fetch.resp_ready) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        accept = fetch.req_valid && fetch.req_ready;
        if (accept) begin
            line_d  = fetch.req_addr[ADDR_W-1:3];
            cnt_d   = '0;
            state_d = READ;
            fault_d = 1'b0;
`ifdef IMEM_FETCH_FAULT_EN
            if (|fetch.req_addr[ADDR_W-1:MEM_AW+1]) begin
                state_d = RESP;
                fault_d = 1'b1;
                asm_clr = 1'b1;
            end
`endif
        end

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            fault_d = 1'b0;
        end
    end

    line_assembler u_line_assembler (
        .clk      (clk),
        .rst      (reset),
        .clr      (asm_clr),
        .cap_en   (asm_cap),
        .cap_idx  (asm_idx),
        .cap_data (mem_rdata),
        .line     (fetch.resp_data)
    );

    assign fetch.resp_addr = {line_q, 3'b000};
    assign dbg_state       = state_q;

`ifdef IMEM_FETCH_FAULT_EN
    assign fetch.resp_fault = fault_q;
`endif

    // The byte offset within a line carries no information for a line fetch.
    logic unused_offset_bits;
    assign unused_offset_bits = ^fetch.req_addr[2:0];

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Memory-side responder for the 64-bit instruction fetch interface that feeds InstructionFetcher's fetchedInstruction input.
- Accepts one fetch request at a time and reads four consecutive 16-bit halfwords from iCE40 SPRAM, which has one-cycle registered read latency.
- Assembles the halfwords into one little-endian 64-bit fetch line and returns it through a valid/ready response.
- Supports a flush that discards in-flight work on a taken branch.

Parameters:
ADDR_W, 32, width of the fetch byte address.
MEM_AW, 14, width of the SPRAM halfword address (16K x 16 = 32 KiB).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
flush  in  1  abort the current request (branch taken); wins over all other events
req_valid  in  1  fetch request present
req_ready  out  1  responder can accept a request
req_addr  in  ADDR_W  byte address of the fetch line; bits [2:0] are ignored
resp_valid  out  1  fetch line available
resp_ready  in  1  consumer takes the line
resp_data  out  64  fetch line; halfword k is at bits [16k+15:16k]
resp_addr  out  ADDR_W  line address of the response, with bits [2:0] = 0
mem_ren  out  1  SPRAM read enable
mem_addr  out  MEM_AW  SPRAM halfword address
mem_rdata  in  16  SPRAM read data, valid the cycle after mem_ren

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, mem_ren=0, mem_addr=0, resp_data=0, resp_addr=0, counters=0.
- Reset is asynchronous; asserting it mid-read drops the request with no response.
- States:
  - IDLE: req_ready=1. On req_valid & req_ready & !flush, latch line={req_addr[ADDR_W-1:3],3'b000} and go to READ with issue count=0.
  - READ: req_ready=0.
    - Issue cycles 0..3: mem_ren=1, mem_addr={line[MEM_AW:3], cnt[1:0]}.
    - Capture: mem_rdata is written into halfword slot (cnt-1) on the edge after each issue.
    - The fourth capture occurs on the 5th edge after acceptance; that edge moves to RESP.
  - RESP: resp_valid=1; resp_data and resp_addr stay stable. On resp_ready go to IDLE; otherwise hold indefinitely.
- Latency: resp_valid rises after the 5th clock edge following the acceptance edge.
- Throughput: one line per 6 cycles when resp_ready is held high.
- mem_ren=0 in IDLE, in RESP, and on the capture-only 5th READ cycle.
- flush:
  - In any state, the next edge goes to IDLE, clears resp_valid, and aborts the issue/capture counts.
  - req_ready is combinationally forced low while flush=1, so a request in the same cycle is not accepted.
  - A request presented the cycle after flush is accepted normally.
- flush and resp_ready together in RESP: the line counts as consumed and the state goes to IDLE (same result either way).
- Address wrap: line bits above MEM_AW+1 are ignored unless FETCH_FAULT_EN is defined. The halfword counter wraps 3 -> 0 only within a line.
- Stale data: the previous line's halfwords are overwritten, never ORed.

Optional Feature:
Macro IMEM_FETCH_FAULT_EN.
- Defined:
  - Adds output resp_fault (1 bit), reset value 0.
  - A request with req_addr[ADDR_W-1:MEM_AW+1] != 0 skips READ and goes from IDLE to RESP on the next edge.
  - In that case: resp_fault=1, resp_data=0, and no mem_ren pulses are issued.
  - resp_fault is cleared on leaving RESP.
- Undefined: no resp_fault port; high address bits are silently truncated (aliasing).

Decomposition:
- Package imem_pkg:
  - state enum (IDLE, READ, RESP);
  - FETCH_W=64, HALF_W=16, HALVES=4;
  - a function building mem_addr from a line address and a halfword index.
- One natural sub-module, line_assembler:
  - 4x16 shift/slot register with a write index;
  - capture enable;
  - 64-bit output.
- The FSM, counters and handshake stay in the top module.

Test Plan:
1. Memory preloaded with halfword h at address h having value 16'hA000+h; request req_addr=32'h0000_0010 -> mem_addr sequence 8,9,10,11; resp_valid 5 cycles after acceptance; resp_data=64'hA00B_A00A_A009_A008; resp_addr=32'h10.
2. req_addr=32'h0000_0017 (misaligned) -> identical response to scenario 1 with resp_addr=32'h10.
3. resp_ready held low 10 cycles -> resp_valid and resp_data stable; req_ready=0 throughout; the next request is accepted only after resp_ready=1 is sampled.
4. flush asserted 2 cycles after acceptance -> state returns to IDLE; no resp_valid ever; a new request at 32'h20 returns halfwords 16..19 with no old-data contamination.
5. Reset asserted during READ -> all outputs at reset values immediately (asynchronous); no response after release.
6. With IMEM_FETCH_FAULT_EN defined: req_addr=32'h0001_0000 -> resp_valid after 1 edge, resp_fault=1, resp_data=0, mem_ren never high.
